// File: rtl/pulse_stretch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : pulse_stretch                                                 |
// | Description : Stretches one-cycle strobes into level windows of len cycles; |
// |               close pulses either retrigger the window or queue replays.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module pulse_stretch #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic [CNT_W-1:0]  len,
  input  logic              retrig,
  input  logic              clr_ovf,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] c_pend_one = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] c_pend_max = {PEND_W{1'b1}};

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_load_val;
  logic [PEND_W-1:0] r_pend, w_pend_nxt;
  logic              r_ovf, w_ovf_set, w_full;

  // A zero length still produces a one-cycle window.
  assign w_load_val = (len == '0) ? '0 : (len - c_cnt_one);
  assign w_full     = (r_pend == c_pend_max);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~clr_ovf);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pulse_in) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = w_load_val;
        end
      end
      S_HIGH: begin
        if (pulse_in && !retrig) begin
          if (w_full) w_ovf_set  = 1'b1;
          else        w_pend_nxt = r_pend + c_pend_one;
        end
        if (pulse_in && retrig) begin
          w_cnt_nxt = w_load_val;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - c_cnt_one;
        end else begin
          // Decision uses the queue depth including this cycle's pulse.
          w_state_nxt = (w_pend_nxt != '0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        w_state_nxt = S_HIGH;
        w_cnt_nxt   = w_load_val;
        // A pulse here offsets the replay's dequeue; a full queue still flags it.
        if (pulse_in) w_ovf_set  = w_full;
        else          w_pend_nxt = r_pend - c_pend_one;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign level_out = (r_state == S_HIGH);
  assign busy      = (r_state != S_IDLE);
  assign pend_cnt  = r_pend;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_pulse_stretch                                              |
// | Description : Randomized scoreboard bench for pulse_stretch.                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_pulse_stretch;

  localparam int CW = 8;
  localparam int PW = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pulse_in = 1'b0;
  logic [CW-1:0] len = '0;
  logic          retrig = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          level_out, busy, ovf;
  logic [PW-1:0] pend_cnt;

  pulse_stretch #(.CNT_W(CW), .PEND_W(PW)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .len(len), .retrig(retrig),
    .clr_ovf(clr_ovf), .level_out(level_out), .busy(busy),
    .pend_cnt(pend_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lvl;
    logic          bsy;
    logic [PW-1:0] pend;
    logic          ov;
  } obs_t;

  obs_t q_exp[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_cyc = 0;

  // Reference: cycles of high time left, a pending gap, a queue depth, a sticky flag.
  int m_hi = 0;
  bit m_gap = 0;
  int m_pend = 0;
  bit m_ovf = 0;

  task automatic model_step(input bit p, input int l, input bit r, input bit c);
    int  win;
    bit  set;
    win = (l == 0) ? 1 : l;
    set = 0;
    if (m_hi > 0) begin
      if (p && r) begin
        m_hi = win;
      end else begin
        if (p) begin
          if (m_pend == PMAX) set = 1;
          else m_pend++;
        end
        m_hi--;
        if (m_hi == 0) m_gap = (m_pend > 0);
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_hi  = win;
      if (p) set = (m_pend == PMAX);
      else   m_pend--;
    end else if (p) begin
      m_hi = win;
    end
    m_ovf = (m_ovf & ~c) | set;
  endtask

  task automatic cyc(input bit p, input int l, input bit r, input bit c, input bit rs);
    obs_t e;
    @(negedge clk);
    n_cyc++;
    if (rs) begin
      rst = 1'b0;
      m_hi = 0; m_gap = 0; m_pend = 0; m_ovf = 0;
    end else begin
      rst = 1'b1;
    end
    e.lvl  = (m_hi > 0);
    e.bsy  = (m_hi > 0) || m_gap;
    e.pend = PW'(m_pend);
    e.ov   = m_ovf;
    q_exp.push_back(e);
    pulse_in = p;
    len      = CW'(l);
    retrig   = r;
    clr_ovf  = c;
    if (!rs) model_step(p, l, r, c);
  endtask

  // Monitor: the DUT presents a fresh output set every cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        a = '{lvl: level_out, bsy: busy, pend: pend_cnt, ov: ovf};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL outputs cyc %0d: got lvl=%b busy=%b pend=%0d ovf=%b, want lvl=%b busy=%b pend=%0d ovf=%b",
                      n_cyc, a.lvl, a.bsy, a.pend, a.ov, e.lvl, e.bsy, e.pend, e.ov);
      end
    end
  end

  initial begin
    bit rmode;
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 3, 0, 0, 0);
    // single window, len=3
    cyc(1, 3, 0, 0, 0);
    repeat (5) cyc(0, 3, 0, 0, 0);
    // len=0 acts as 1
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    // queued replay with gap
    cyc(1, 2, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    repeat (7) cyc(0, 2, 0, 0, 0);
    // retrigger extends window
    cyc(1, 4, 1, 0, 0);
    cyc(0, 4, 1, 0, 0);
    cyc(1, 4, 1, 0, 0);
    repeat (8) cyc(0, 4, 1, 0, 0);
    // saturation, set-beats-clear, then plain clear
    repeat (5) cyc(1, 8, 0, 0, 0);
    cyc(1, 8, 0, 1, 0);
    cyc(0, 8, 0, 0, 0);
    cyc(0, 8, 0, 1, 0);
    repeat (40) cyc(0, 8, 0, 0, 0);
    // reset aborts queued replay
    cyc(1, 6, 0, 0, 0);
    cyc(1, 6, 0, 0, 0);
    cyc(0, 6, 0, 0, 0);
    cyc(0, 6, 0, 0, 1);
    repeat (12) cyc(0, 6, 0, 0, 0);
    // random traffic
    rmode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rmode = ~rmode;
      cyc(($urandom_range(0, 9) < 4), int'($urandom_range(0, 5)), rmode,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
    end
    repeat (2) @(negedge clk);
    #3;
    n_chk++;
    if (q_exp.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, want 0", q_exp.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
